oddr_serializer: RTL and testbench

Parametrised multi-lane output serializer with a DDR launch stage. Accepts parallel words of RATIO bits per lane over a valid/ready handshake. Shifts each word out two bits per clock: one bit on the high phase and one on the low phase. Drives gapless streams when words arrive back-to-back, and an idle level otherwise. Sits between MAC/PHY-side framing logic and device pins, replacing hand-instantiated DDR output flops.

---
 rtl/oddr_ser_pkg.sv | 22 ++
 rtl/oddr_lane.sv | 54 +++++
 rtl/oddr_serializer.sv | 190 +++++++++++++++++++
 tb/tb_oddr_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oddr_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oddr_ser_pkg
//  Purpose  : Shared types and constants for the oddr_serializer block.
//  Revision : 1.0  initial release
// ============================================================================
package oddr_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        TRAIN = 2'd2
    } state_t;

    localparam logic [7:0] c_TRAIN_PATTERN = 8'b0101_0011;

    function automatic bit ratio_is_legal(input int ratio);
        return (ratio >= 2) && (ratio <= 16) && ((ratio % 2) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oddr_lane.sv
`default_nettype none
// ============================================================================
//  Module   : oddr_lane
//  Purpose  : One lane of DDR launch: d1 shown in the high phase, d2 in the
//             low phase, async reset to the lane idle level.
//  Revision : 1.0  initial release
// ============================================================================
module oddr_lane #(
    parameter string TARGET   = "GENERIC",
    parameter logic  IDLE_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d1,
    input  logic d2,
    output logic q
);

    logic d1_q;
    logic d2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= IDLE_BIT;
            d2_q <= IDLE_BIT;
        end else begin
            d1_q <= d1;
            d2_q <= d2;
        end
    end

    if (TARGET == "SIM") begin : g_sim
        assign q = clk ? d1_q : d2_q;
    end else if ((TARGET == "GENERIC") || (TARGET == "XILINX") || (TARGET == "ALTERA")) begin : g_fabric
        // Falling-edge retime keeps the low-phase bit stable across the mux
        // switch; vendor IO packers absorb this pair into their ODDR cell.
        logic d2_n_q;

        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                d2_n_q <= IDLE_BIT;
            end else begin
                d2_n_q <= d2_q;
            end
        end

        assign q = clk ? d1_q : d2_n_q;
    end else begin : g_bad_target
        $error("oddr_lane: unsupported TARGET");
        assign q = IDLE_BIT;
    end

endmodule
`default_nettype wire

// File: rtl/oddr_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : oddr_serializer
//  Purpose  : Multi-lane word serializer with DDR launch, two bits per clock.
//             Optional training mode enabled by macro ODDR_SER_TRAINING_EN.
//  Revision : 1.0  initial release
// ============================================================================
module oddr_serializer
    import oddr_ser_pkg::*;
#(
    parameter string            TARGET        = "GENERIC",
    parameter int               WIDTH         = 4,
    parameter int               RATIO         = 8,
    parameter logic [WIDTH-1:0] IDLE_VALUE    = {WIDTH{1'b0}},
    parameter logic [7:0]       TRAIN_PATTERN = c_TRAIN_PATTERN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH*RATIO-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic                   underflow
`ifdef ODDR_SER_TRAINING_EN
    ,
    input  logic                   train_en
`endif
);

    localparam int               c_DATA_W     = WIDTH * RATIO;
    localparam logic [2:0]       c_LAST_BEAT  = 3'(RATIO / 2 - 1);
    localparam logic [RATIO-1:0] c_TRAIN_WORD = RATIO'(TRAIN_PATTERN);

    if (!ratio_is_legal(RATIO)) begin : g_bad_ratio
        $error("oddr_serializer: RATIO must be even and within 2..16");
    end

    state_t                state_q, state_d;
    logic [c_DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]            beat_q, beat_d;
    logic                  shift_v_q, shift_v_d;
    logic [c_DATA_W-1:0]   hold_q, hold_d;
    logic                  hold_v_q, hold_v_d;
    logic [WIDTH-1:0]      pair_d1_q, pair_d1_d;
    logic [WIDTH-1:0]      pair_d2_q, pair_d2_d;
    logic                  pair_v_q, pair_v_d;
    logic                  lane_v_q, lane_v_d;
    logic                  underflow_q, underflow_d;
    logic                  rdy_en_q, rdy_en_d;

    logic                  w_train_en;
    logic                  w_last;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_beat_d1;
    logic [WIDTH-1:0]      w_beat_d2;
    logic [c_DATA_W-1:0]   w_shift_adv;

`ifdef ODDR_SER_TRAINING_EN
    assign w_train_en = train_en;
`else
    assign w_train_en = 1'b0;
`endif

    // Each lane presents its two lowest bits and then shifts down by a pair.
    for (genvar n = 0; n < WIDTH; n++) begin : g_beat
        assign w_beat_d1[n] = shift_q[n*RATIO];
        assign w_beat_d2[n] = shift_q[n*RATIO + 1];
        assign w_shift_adv[n*RATIO +: RATIO] = shift_q[n*RATIO +: RATIO] >> 2;
    end

    assign w_last    = shift_v_q && (beat_q == c_LAST_BEAT);
    assign s_ready   = rdy_en_q && !hold_v_q && (state_q != TRAIN)
                       && !((state_q == IDLE) && w_train_en);
    assign w_accept  = s_valid && s_ready;
    assign busy      = shift_v_q | hold_v_q | pair_v_q | lane_v_q;
    assign underflow = underflow_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        beat_d      = beat_q;
        shift_v_d   = shift_v_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        underflow_d = 1'b0;
        rdy_en_d    = 1'b1;
        pair_v_d    = shift_v_q;
        lane_v_d    = pair_v_q;
        pair_d1_d   = shift_v_q ? w_beat_d1 : IDLE_VALUE;
        pair_d2_d   = shift_v_q ? w_beat_d2 : IDLE_VALUE;

        if (shift_v_q) begin
            shift_d   = w_shift_adv;
            beat_d    = w_last ? 3'd0 : beat_q + 3'd1;
            shift_v_d = !w_last;
        end

        case (state_q)
            IDLE: begin
                if (w_train_en) begin
                    state_d   = TRAIN;
                    shift_d   = {WIDTH{c_TRAIN_WORD}};
                    shift_v_d = 1'b1;
                    beat_d    = 3'd0;
                end else if (w_accept) begin
                    state_d   = RUN;
                    shift_d   = s_data;
                    shift_v_d = 1'b1;
                    beat_d    = 3'd0;
                end
            end
            RUN: begin
                if (w_last) begin
                    if (hold_v_q) begin
                        shift_d   = hold_q;
                        shift_v_d = 1'b1;
                        hold_v_d  = 1'b0;
                    end else if (w_accept) begin
                        shift_d   = s_data;
                        shift_v_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        underflow_d = 1'b1;
                    end
                end else if (w_accept) begin
                    hold_d   = s_data;
                    hold_v_d = 1'b1;
                end
            end
            TRAIN: begin
                // Exit only at a pattern boundary so no partial pattern is sent.
                if (w_last) begin
                    if (w_train_en) begin
                        shift_d   = {WIDTH{c_TRAIN_WORD}};
                        shift_v_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            beat_q      <= 3'd0;
            shift_v_q   <= 1'b0;
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            pair_d1_q   <= IDLE_VALUE;
            pair_d2_q   <= IDLE_VALUE;
            pair_v_q    <= 1'b0;
            lane_v_q    <= 1'b0;
            underflow_q <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            beat_q      <= beat_d;
            shift_v_q   <= shift_v_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            pair_d1_q   <= pair_d1_d;
            pair_d2_q   <= pair_d2_d;
            pair_v_q    <= pair_v_d;
            lane_v_q    <= lane_v_d;
            underflow_q <= underflow_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_lane
        oddr_lane #(
            .TARGET   (TARGET),
            .IDLE_BIT (IDLE_VALUE[n])
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .d1  (pair_d1_q[n]),
            .d2  (pair_d2_q[n]),
            .q   (q[n])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_oddr_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oddr_serializer
//  Purpose  : Directed self-checking bench for oddr_serializer (three configs).
//  Revision : 1.0  initial release
// ============================================================================
module tb_oddr_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: 4 lanes x 8 bits, idle low
    logic [31:0] s_data_a  = '0;
    logic        s_valid_a = 1'b0;
    logic        s_ready_a;
    logic [3:0]  q_a;
    logic        busy_a, uf_a;
    // B: 1 lane x 4 bits, idle high, SIM lane cell
    logic [3:0]  s_data_b  = '0;
    logic        s_valid_b = 1'b0;
    logic        s_ready_b;
    logic [0:0]  q_b;
    logic        busy_b, uf_b;
    // C: 2 lanes x 2 bits, idle 2'b10
    logic [3:0]  s_data_c  = '0;
    logic        s_valid_c = 1'b0;
    logic        s_ready_c;
    logic [1:0]  q_c;
    logic        busy_c, uf_c;
`ifdef ODDR_SER_TRAINING_EN
    logic train_en_a = 1'b0;
    logic train_en_b = 1'b0;
    logic train_en_c = 1'b0;
`endif

    oddr_serializer #(.TARGET("GENERIC"), .WIDTH(4), .RATIO(8), .IDLE_VALUE(4'b0000)) u_dut_a (
        .clk(clk), .rst(rst), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .q(q_a), .busy(busy_a), .underflow(uf_a)
`ifdef ODDR_SER_TRAINING_EN
        , .train_en(train_en_a)
`endif
    );

    oddr_serializer #(.TARGET("SIM"), .WIDTH(1), .RATIO(4), .IDLE_VALUE(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .q(q_b), .busy(busy_b), .underflow(uf_b)
`ifdef ODDR_SER_TRAINING_EN
        , .train_en(train_en_b)
`endif
    );

    oddr_serializer #(.TARGET("GENERIC"), .WIDTH(2), .RATIO(2), .IDLE_VALUE(2'b10)) u_dut_c (
        .clk(clk), .rst(rst), .s_data(s_data_c), .s_valid(s_valid_c), .s_ready(s_ready_c),
        .q(q_c), .busy(busy_c), .underflow(uf_c)
`ifdef ODDR_SER_TRAINING_EN
        , .train_en(train_en_c)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int uf_cnt_a = 0;
    int uf_cnt_b = 0;
    int uf_cnt_c = 0;

    always @(negedge clk) begin
        if (uf_a) uf_cnt_a <= uf_cnt_a + 1;
        if (uf_b) uf_cnt_b <= uf_cnt_b + 1;
        if (uf_c) uf_cnt_c <= uf_cnt_c + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; returns after the low phase of the last beat.
    task automatic send_word_a(input logic [31:0] data, output logic [31:0] got);
        got = '0;
        s_data_a  = data;
        s_valid_a = 1'b1;
        @(posedge clk); #1;
        s_valid_a = 1'b0;
        @(posedge clk); #1;
        check_val("latency_idle_a", q_a, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 2) check_val("uf_align_a", uf_a, 1);
            for (int n = 0; n < 4; n++) got[n*8 + 2*k] = q_a[n];
            @(negedge clk); #1;
            for (int n = 0; n < 4; n++) got[n*8 + 2*k + 1] = q_a[n];
        end
    endtask

    logic [31:0] got32;
    logic [11:0] got12;
    logic [7:0]  got_c0, got_c1;
    logic [3:0]  rlog;
    logic [3:0]  resid;
    int          base;
    int          cyc;
    int          idx;
    logic [3:0]  words_b [3] = '{4'h6, 4'h9, 4'hC};
    logic [3:0]  words_c [4] = '{4'h6, 4'h9, 4'hC, 4'h3};
`ifdef ODDR_SER_TRAINING_EN
    logic [23:0] got_t0, got_t3;
    logic        rdy_or;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready_a", s_ready_a, 0);
        check_val("rst_q_a", q_a, 4'h0);
        check_val("rst_q_b", q_b, 1'b1);
        check_val("rst_q_c", q_c, 2'b10);
        check_val("rst_busy_a", busy_a, 0);
        check_val("rst_uf_a", uf_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_rst_a", s_ready_a, 1);

        // Single word, lane 0 = A5
        base = uf_cnt_a;
        send_word_a(32'h0000_00A5, got32);
        check_val("single_a5", got32, 32'h0000_00A5);
        check_val("single_uf_cnt", uf_cnt_a - base, 1);
        check_val("busy_tail_a", busy_a, 1);
        @(posedge clk); #1;
        check_val("busy_fall_a", busy_a, 0);
        check_val("idle_after_a", q_a, 4'h0);

        // Distinct lane bytes 01/80/FF/00
        send_word_a(32'h00FF_8001, got32);
        check_val("lanes_distinct", got32, 32'h00FF_8001);
        @(posedge clk); #1;

        // Back-to-back on B, s_valid held high
        base = uf_cnt_b; rlog = '0; cyc = 0; idx = 0; got12 = '0;
        fork
            begin : drv_b
                s_valid_b = 1'b1;
                while (idx < 3 && cyc < 20) begin
                    s_data_b = words_b[idx];
                    if (cyc < 4) rlog[cyc] = s_ready_b;
                    if (s_ready_b) idx++;
                    cyc++;
                    @(posedge clk); #1;
                end
                s_valid_b = 1'b0;
            end
            begin : cap_b
                @(posedge clk);
                @(posedge clk);
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk); #1;
                    got12[2*k] = q_b[0];
                    @(negedge clk); #1;
                    got12[2*k + 1] = q_b[0];
                end
            end
        join
        check_val("b2b_ready_pattern", rlog, 4'b1011);
        check_val("b2b_accept_cycles", cyc, 4);
        check_val("b2b_stream", got12, 12'hC96);
        check_val("b2b_uf_cnt", uf_cnt_b - base, 1);
        @(posedge clk); #1;
        check_val("b2b_idle_q", q_b, 1'b1);
        check_val("b2b_busy_fall", busy_b, 0);

        // RATIO=2 on C: one word per cycle
        base = uf_cnt_c; rlog = '0; cyc = 0; idx = 0; got_c0 = '0; got_c1 = '0;
        fork
            begin : drv_c
                s_valid_c = 1'b1;
                while (idx < 4 && cyc < 20) begin
                    s_data_c = words_c[idx];
                    if (cyc < 4) rlog[cyc] = s_ready_c;
                    if (s_ready_c) idx++;
                    cyc++;
                    @(posedge clk); #1;
                end
                s_valid_c = 1'b0;
            end
            begin : cap_c
                @(posedge clk);
                @(posedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    got_c0[2*k] = q_c[0];
                    got_c1[2*k] = q_c[1];
                    @(negedge clk); #1;
                    got_c0[2*k + 1] = q_c[0];
                    got_c1[2*k + 1] = q_c[1];
                end
            end
        join
        check_val("r2_ready_pattern", rlog, 4'b1111);
        check_val("r2_accept_cycles", cyc, 4);
        check_val("r2_lane0", got_c0, 8'hC6);
        check_val("r2_lane1", got_c1, 8'h39);
        check_val("r2_uf_cnt", uf_cnt_c - base, 1);
        check_val("r2_busy_tail", busy_c, 1);
        @(posedge clk); #1;
        check_val("r2_busy_fall", busy_c, 0);
        check_val("r2_idle_q", q_c, 2'b10);

        // Reset in the middle of a word on A
        base = uf_cnt_a;
        s_data_a  = 32'hFFFF_FFFF;
        s_valid_a = 1'b1;
        @(posedge clk); #1;
        s_valid_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("midword_q", q_a, 4'hF);
        #2 rst = 1'b1;
        #1;
        check_val("rst_async_q", q_a, 4'h0);
        check_val("rst_async_ready", s_ready_a, 0);
        check_val("rst_async_busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_midrst", s_ready_a, 1);
        resid = '0;
        for (int k = 0; k < 6; k++) begin
            resid = resid | q_a | {3'b000, busy_a};
            @(negedge clk); #1;
            resid = resid | q_a;
            @(posedge clk); #1;
        end
        check_val("no_residual", resid, 4'h0);
        check_val("midrst_no_uf", uf_cnt_a - base, 0);

`ifdef ODDR_SER_TRAINING_EN
        // Training for 2.5 pattern lengths: three whole patterns expected
        base = uf_cnt_a; got_t0 = '0; got_t3 = '0;
        train_en_a = 1'b1;
        #1;
        rdy_or = s_ready_a;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c == 9) train_en_a = 1'b0;
            if (c < 12) rdy_or = rdy_or | s_ready_a;
            if (c >= 2) begin
                got_t0[2*(c-2)] = q_a[0];
                got_t3[2*(c-2)] = q_a[3];
                @(negedge clk); #1;
                got_t0[2*(c-2) + 1] = q_a[0];
                got_t3[2*(c-2) + 1] = q_a[3];
            end
        end
        check_val("train_lane0", got_t0, 24'h535353);
        check_val("train_lane3", got_t3, 24'h535353);
        check_val("train_ready_low", rdy_or, 0);
        check_val("train_no_uf", uf_cnt_a - base, 0);
        check_val("train_back_idle", s_ready_a, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
